rtype_sequencer: RTL
====================

Name: rtype_sequencer

Overview:
Multi-cycle control FSM that drives the R-type execution path: instruction fetch address, register-file read/write addresses, ALU control and write enable. It runs one R-type instruction in 4 cycles (FETCH, DECODE, EXEC, WB) and stops after a programmed instruction count or on an illegal encoding. It sits between the instruction memory and the existing register-file/ALU datapath, and replaces free-running stepping of that datapath.

Parameters:
PC_W, 32, width of pc output (byte address).
CNT_W, 8, width of instruction counter and num_instr input.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; forces the IDLE state and all reset values.
start  input  1  level; sampled only in IDLE and DONE.
num_instr  input  CNT_W  number of instructions to run; sampled on start in IDLE.
instr  input  32  instruction-memory read data for the address on pc (combinational memory).
pc  output  PC_W  instruction byte address.
rs_addr  output  5  register-file read port A address.
rt_addr  output  5  register-file read port B address.
rd_addr  output  5  register-file write address.
alu_ctrl  output  4  ALU operation select.
rf_we  output  1  register-file write enable.
busy  output  1  high in FETCH, DECODE, EXEC and WB.
done  output  1  high in DONE.
err  output  1  high in ERROR.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, DONE, ERROR. All outputs are registered or decoded from state and IR only (Moore); no output depends combinationally on start.
- Reset values: state IDLE; pc, IR, count, rs_addr, rt_addr, rd_addr, alu_ctrl all 0; rf_we, busy, done, err all 0.
- IDLE: if start=1 and num_instr!=0: pc<=0, count<=0, latch num_instr, go to FETCH. If start=1 and num_instr=0: go directly to DONE.
- FETCH: IR<=instr at the clock edge; go to DECODE.
- DECODE: rs_addr=IR[25:21], rt_addr=IR[20:16], rd_addr=IR[15:11].
  - If IR[31:26]!=0 or funct is unsupported, go to ERROR.
  - Otherwise go to EXEC.
- Funct-to-alu_ctrl mapping: 0x24 (and) -> 0000; 0x25 (or) -> 0001; 0x20 (add) -> 0010; 0x22 (sub) -> 0110; 0x2A (slt) -> 0111; 0x27 (nor) -> 1100. shamt is ignored.
- EXEC: alu_ctrl is valid; go to WB.
- WB: rf_we=1 for exactly this one cycle, except rf_we=0 when rd_addr=0. At the exit edge: pc<=pc+4 (wraps modulo 2^PC_W) and count<=count+1. If count+1==latched num_instr, go to DONE; else go to FETCH.
- Latency: 4 cycles per instruction. A run of N instructions enters DONE 4N cycles after leaving IDLE.
- Address and alu_ctrl outputs hold their last values outside DECODE/EXEC/WB, and are 0 after reset.
- DONE: done=1 and pc is held. Go to IDLE when start=0. If start stays 1, remain in DONE (no auto-restart).
- ERROR: err=1. pc holds the address of the offending instruction. No rf_we is issued for that instruction. Only reset leaves ERROR.
- start while busy is ignored. num_instr changes after the start sample are ignored.
- Reset mid-operation: takes effect immediately without a clock. rf_we drops to 0 at once and no partial writeback occurs.

Test Plan:
- Reset then idle: reset=1, clock running, start=0 -> pc=0, rf_we=0, busy=0, done=0, err=0 for 10 cycles.
- Two instructions: num_instr=2, imem[0]=0x00221820 (add $3,$1,$2), imem[4]=0x00612022 (sub $4,$3,$1).
  - Instruction 1 -> rs=1, rt=2, rd=3, alu_ctrl=0010, single rf_we pulse 4 cycles after FETCH entry.
  - Instruction 2 -> rs=3, rt=1, rd=4, alu_ctrl=0110.
  - End of run -> done=1 exactly 8 cycles after leaving IDLE, pc=8.
- Illegal opcode: imem[0]=0x8C220000 (lw) -> err=1 after DECODE, rf_we never asserted, pc=0, state stuck until reset.
- Write to $0: imem[0]=0x00010020 (add $0,$0,$1), num_instr=1 -> rf_we stays 0 throughout, pc=4, done=1.
- Reset during EXEC of 0x00221825 (or) -> all outputs return to reset values without a clock edge, no rf_we pulse; a subsequent start re-runs from pc=0.
- Edge cases:
  - start pulsed again during busy -> ignored, count unaffected.
  - num_instr=0 -> DONE on the next edge with no FETCH.
  - start held high in DONE -> stays in DONE, then returns to IDLE once start=0.

Source files
------------

// File: rtl/rtype_sequencer.sv
// Multi-cycle control FSM for the R-type execution path: fetches, decodes and
// sequences one instruction every four cycles until a programmed count is reached.
module rtype_sequencer #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_instr,
  input  logic [31:0]      instr,
  output logic [PC_W-1:0]  pc,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic [3:0]       alu_ctrl,
  output logic             rf_we,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, DONE, ERROR} state_t;

  state_t           state;
  state_t           next_state;
  logic [31:0]      ir;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] num_latched;
  logic [CNT_W-1:0] count_inc;
  logic [4:0]       rs_held;
  logic [4:0]       rt_held;
  logic [4:0]       rd_held;
  logic [3:0]       alu_held;
  logic [3:0]       alu_dec;
  logic             funct_ok;
  logic             in_exec;

  assign count_inc = count + CNT_W'(1);
  assign in_exec   = (state == DECODE) || (state == EXEC) || (state == WB);

  always_comb begin
    funct_ok = 1'b1;
    alu_dec  = 4'b0000;
    case (ir[5:0])
      6'h24:   alu_dec = 4'b0000;
      6'h25:   alu_dec = 4'b0001;
      6'h20:   alu_dec = 4'b0010;
      6'h22:   alu_dec = 4'b0110;
      6'h2A:   alu_dec = 4'b0111;
      6'h27:   alu_dec = 4'b1100;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = (num_instr != '0) ? FETCH : DONE;
      end
      FETCH:  next_state = DECODE;
      DECODE: next_state = ((ir[31:26] != 6'd0) || !funct_ok) ? ERROR : EXEC;
      EXEC:   next_state = WB;
      WB:     next_state = (count_inc == num_latched) ? DONE : FETCH;
      DONE: begin
        if (!start) next_state = IDLE;
      end
      ERROR:   next_state = ERROR;
      default: next_state = IDLE;
    endcase
  end

  // Held copies keep the address/ALU outputs stable once the instruction retires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      ir          <= '0;
      count       <= '0;
      num_latched <= '0;
      rs_held     <= '0;
      rt_held     <= '0;
      rd_held     <= '0;
      alu_held    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (num_instr != '0)) begin
            pc          <= '0;
            count       <= '0;
            num_latched <= num_instr;
          end
        end
        FETCH: ir <= instr;
        DECODE: begin
          rs_held  <= ir[25:21];
          rt_held  <= ir[20:16];
          rd_held  <= ir[15:11];
          alu_held <= alu_dec;
        end
        WB: begin
          pc    <= pc + PC_W'(4);
          count <= count_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state == FETCH) || in_exec;
    done     = (state == DONE);
    err      = (state == ERROR);
    rf_we    = (state == WB) && (ir[15:11] != 5'd0);
    rs_addr  = in_exec ? ir[25:21] : rs_held;
    rt_addr  = in_exec ? ir[20:16] : rt_held;
    rd_addr  = in_exec ? ir[15:11] : rd_held;
    alu_ctrl = in_exec ? alu_dec : alu_held;
  end

endmodule
